id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the five-stage processor. It sits directly downstream of the control unit (CU) and the register-file read, and feeds the EX stage.
- Latches the CU control bundle (dmr, dmw, data_read, data_write, alu_function), register addresses and operand values each cycle.
- Contains the load-use hazard detector: on a hazard it inserts a one-cycle bubble and stalls IF/ID and PC.
- Honours EX back-pressure and branch flush, and keeps a saturating load-use stall counter for performance debug.

Parameters:
DATA_W, 16, operand width
REG_AW, 3, register address width (8 GPRs)
ALU_FW, 3, alu_function width (CU encoding: 00 NOP/LOAD, 01 NOT, 10 MOV/STORE, 11 ADD, zero-extended)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
id_valid  in  1  ID holds a real instruction
id_dmr  in  1  CU data-memory read
id_dmw  in  1  CU data-memory write
id_data_read  in  1  CU: instruction reads register file
id_data_write  in  1  CU: instruction writes register file
id_alu_function  in  ALU_FW  CU ALU function
id_rs1, id_rs2, id_rd  in  REG_AW each  source/destination addresses
id_rs1_val, id_rs2_val  in  DATA_W each  register-file read data
flush  in  1  branch taken in EX; kill the ID instruction
ex_stall  in  1  EX/MEM cannot accept; hold
ex_valid, ex_dmr, ex_dmw, ex_data_read, ex_data_write  out  1 each  registered control
ex_alu_function  out  ALU_FW  registered ALU function
ex_rs1, ex_rs2, ex_rd  out  REG_AW each  registered addresses
ex_rs1_val, ex_rs2_val  out  DATA_W each  registered operands
id_stall  out  1  combinational; freeze PC and IF/ID
stall_count  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (rst_n=0 at posedge): all ex_* outputs = 0 (bubble) and stall_count = 0. id_stall follows the combinational rule below, and evaluates to 0 because ex_valid=0 after reset. Reset mid-stall drops the held instruction.
- hazard (combinational) = id_valid & id_data_read & ex_valid & ex_dmr & ex_data_write & (ex_rd==id_rs1 | ex_rd==id_rs2).
- id_stall = ~flush & (ex_stall | hazard).
- Per-posedge update priority: reset > flush > ex_stall > hazard > normal.
  - flush: load a bubble (all ex_* = 0). ex_stall is ignored this cycle.
  - ex_stall: hold all ex_* unchanged.
  - hazard: load a bubble and increment stall_count.
  - normal: latch all id_* into ex_*. ex_valid = id_valid. When id_valid=0, control outputs = 0 and data/address outputs still latch.
- Latency: 1 cycle from ID to EX outputs. A load-use pair costs exactly one bubble, because the next cycle ex_valid=0 so hazard clears.
- Hazard concurrent with ex_stall: hold; no bubble; counter unchanged. The bubble is inserted on the first non-stalled cycle if the hazard still holds.
- stall_count saturates at 2^CNT_W-1 and does not wrap. It is cleared only by reset.
- rs compare is done on addresses only. Compare against GPR 0 is not special-cased.
- Outputs are registered, except id_stall.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random id_* -> all ex_*=0, stall_count=0, id_stall=0.
- Pass-through: ADD id_valid=1, data_read=1, data_write=1, alu_function=3'b011, rs1=1, rs2=2, rd=3, vals 16'h1234/16'h0042 -> next cycle ex_* equal those values, id_stall=0.
- Load-use: LOAD rd=5 (dmr=1, data_write=1, alu=000), then ADD with rs1=5 -> id_stall=1 for one cycle, EX gets a bubble (ex_valid=0), ADD appears in EX the following cycle, stall_count=1. Repeat with rs2=5 -> stall_count=2. Repeat with rs1=rs2=4 -> no stall.
- Back-pressure: ex_stall=1 for 3 cycles while ID presents NOT (alu=001) -> ex_* hold the prior instruction and id_stall=1. After release, NOT enters EX. Hazard during ex_stall -> counter unchanged until release.
- Flush: flush=1 concurrent with hazard and ex_stall -> EX gets a bubble, id_stall=0, stall_count unchanged.
- Saturation: force 65537 load-use pairs (or CNT_W=4 with 17 pairs) -> stall_count stays 16'hFFFF (4'hF).

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Latency: 1 cycle from ID inputs to ex_* outputs; id_stall is combinational (same cycle).
// Backpressure: ex_stall holds the EX bundle and raises id_stall; a flush overrides both and loads a bubble.
module id_ex_stage_reg #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int ALU_FW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_dmr,
    input  logic              id_dmw,
    input  logic              id_data_read,
    input  logic              id_data_write,
    input  logic [ALU_FW-1:0] id_alu_function,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs1_val,
    input  logic [DATA_W-1:0] id_rs2_val,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              ex_valid,
    output logic              ex_dmr,
    output logic              ex_dmw,
    output logic              ex_data_read,
    output logic              ex_data_write,
    output logic [ALU_FW-1:0] ex_alu_function,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rs1_val,
    output logic [DATA_W-1:0] ex_rs2_val,
    output logic              id_stall,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic              dmr;
        logic              dmw;
        logic              data_read;
        logic              data_write;
        logic [ALU_FW-1:0] alu_function;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs1_val;
        logic [DATA_W-1:0] rs2_val;
    } ex_bundle_t;

    ex_bundle_t       ex_q, ex_d;
    ex_bundle_t       id_pkt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    // Build the incoming bundle; control fields are squashed for an empty ID slot
    // so a non-instruction can never trigger memory or register-file side effects.
    always_comb begin
        id_pkt              = '0;
        id_pkt.valid        = id_valid;
        id_pkt.dmr          = id_valid & id_dmr;
        id_pkt.dmw          = id_valid & id_dmw;
        id_pkt.data_read    = id_valid & id_data_read;
        id_pkt.data_write   = id_valid & id_data_write;
        id_pkt.alu_function = id_valid ? id_alu_function : '0;
        id_pkt.rs1          = id_rs1;
        id_pkt.rs2          = id_rs2;
        id_pkt.rd           = id_rd;
        id_pkt.rs1_val      = id_rs1_val;
        id_pkt.rs2_val      = id_rs2_val;
    end

    // Load-use detection: the load in EX has not produced data yet, so a dependent
    // instruction in ID must wait one cycle. Address-only compare, r0 included.
    always_comb begin
        hazard   = id_valid & id_data_read & ex_q.valid & ex_q.dmr & ex_q.data_write &
                   ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
        id_stall = ~flush & (ex_stall | hazard);
    end

    // Next-state selection: flush beats back-pressure, back-pressure beats the hazard bubble.
    always_comb begin
        ex_d  = id_pkt;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (ex_stall) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d  = '0;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    // Stage register with synchronous active-low reset; reset drops any held instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid        = ex_q.valid;
    assign ex_dmr          = ex_q.dmr;
    assign ex_dmw          = ex_q.dmw;
    assign ex_data_read    = ex_q.data_read;
    assign ex_data_write   = ex_q.data_write;
    assign ex_alu_function = ex_q.alu_function;
    assign ex_rs1          = ex_q.rs1;
    assign ex_rs2          = ex_q.rs2;
    assign ex_rd           = ex_q.rd;
    assign ex_rs1_val      = ex_q.rs1_val;
    assign ex_rs2_val      = ex_q.rs2_val;
    assign stall_count     = cnt_q;

endmodule
